// File: rtl/conv_stream_engine_if.sv
// Handshake bundle for conv_stream_engine: job control, tap input stream, result output stream.
// Both streams use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// a producer holds its payload steady while valid is high and not yet accepted.
interface conv_stream_engine_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] bias;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_weight;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output start, bias, in_valid, in_data, in_weight, out_ready,
    input  busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weight, out_ready,
    output busy, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_stream_engine.sv
// Sign-magnitude saturating multiply-accumulate over KSIZE*KSIZE taps, plus bias, optional ReLU.
// Define CONV_RELU_EN to clamp negative results to +0.
module conv_stream_engine #(
  parameter int KSIZE = 7,
  parameter int WIDTH = 32,
  parameter int FRAC  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_stream_engine_if.slave  bus,
  output logic [1:0]           dbg_state_o
);
  localparam int MW    = WIDTH - 1;
  localparam int NTAPS = KSIZE * KSIZE;
  localparam int CW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_t;

  state_t           state_q;
  logic [CW-1:0]    tap_cnt_q;
  logic [WIDTH-1:0] acc_q, bias_q, out_data_q;
  logic             in_ready_q, out_valid_q, busy_q;

  function automatic logic [WIDTH-1:0] sm_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [MW:0]   sum;
    logic [MW-1:0] mag;
    logic          sgn;
    if (a[MW] == b[MW]) begin
      sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
      mag = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
      sgn = a[MW];
    end else if (a[MW-1:0] >= b[MW-1:0]) begin
      mag = a[MW-1:0] - b[MW-1:0];
      sgn = a[MW];
    end else begin
      mag = b[MW-1:0] - a[MW-1:0];
      sgn = b[MW];
    end
    // Zero always leaves as +0 so -0 never propagates.
    return {sgn & (|mag), mag};
  endfunction

  function automatic logic [WIDTH-1:0] sm_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*MW-1:0] p;
    logic [2*MW-1:0] ps;
    logic [MW-1:0]   mag;
    p   = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
    ps  = p >> FRAC;
    mag = (|ps[2*MW-1:MW]) ? {MW{1'b1}} : ps[MW-1:0];
    return {(a[MW] ^ b[MW]) & (|mag), mag};
  endfunction

  function automatic logic [WIDTH-1:0] post(input logic [WIDTH-1:0] x);
`ifdef CONV_RELU_EN
    return x[MW] ? '0 : x;
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            bias_q     <= bus.bias;
            acc_q      <= '0;
            tap_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q <= sm_add(acc_q, sm_mul(bus.in_data, bus.in_weight));
            if (tap_cnt_q == LAST_TAP) begin
              in_ready_q <= 1'b0;
              state_q    <= S_BIAS;
            end else begin
              tap_cnt_q <= tap_cnt_q + 1'b1;
            end
          end
        end
        S_BIAS: begin
          out_data_q  <= post(sm_add(acc_q, bias_q));
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine with KSIZE=2: fixed vectors plus small random integer jobs,
// results checked through an expected-value queue popped on each output handshake.
module tb_conv_stream_engine;
  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h0000_8000;
  localparam logic [W-1:0] TWO = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] tap_d[4];
  logic [W-1:0] tap_w[4];

  conv_stream_engine_if #(.WIDTH(W)) ifc();

  conv_stream_engine #(.KSIZE(2), .WIDTH(W), .FRAC(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Consumer side: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", ifc.out_data, 32'hDEAD_BEEF);
      else check("out_data", ifc.out_data, exp_q.pop_front());
    end
  end

  function automatic logic [W-1:0] enc(input int v);
    logic [W-2:0] m;
    m = (W-1)'(v < 0 ? -v : v) << 15;
    return {(v < 0) && (m != 0), m};
  endfunction

  task automatic send_tap(input int i, input bit gap);
    int n;
    if (gap) begin
      ifc.in_valid = 1'b0;
      ifc.in_data = $urandom;
      ifc.in_weight = $urandom;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b1;
    ifc.in_data = tap_d[i];
    ifc.in_weight = tap_w[i];
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("tap_timeout", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] exp, input bit gaps, input bit stall);
    logic [W-1:0] held;
    exp_q.push_back(exp);
    ifc.out_ready = !stall;
    ifc.start = 1'b1;
    ifc.bias = b;
    ifc.in_valid = 1'b1;  // must not be consumed alongside start
    ifc.in_data = tap_d[0];
    ifc.in_weight = tap_w[0];
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.bias = $urandom;
    check("busy_accum", 32'(ifc.busy), 32'd1);
    check("rdy_accum", 32'(ifc.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_tap(i, gaps);
    ifc.in_valid = 1'b0;
    check("rdy_drop", 32'(ifc.in_ready), 32'd0);
    check("lat_early", 32'(ifc.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(ifc.out_valid), 32'd1);
    if (!stall) begin
      @(posedge clk); #1;
      check("valid_one_cycle", 32'(ifc.out_valid), 32'd0);
      check("busy_idle", 32'(ifc.busy), 32'd0);
    end else begin
      held = ifc.out_data;
      for (int c = 0; c < 5; c++) begin
        ifc.start = (c == 2);
        @(posedge clk); #1;
        check("stall_valid", 32'(ifc.out_valid), 32'd1);
        check("stall_data", ifc.out_data, held);
        check("stall_rdy", 32'(ifc.in_ready), 32'd0);
      end
      check("stall_busy", 32'(ifc.busy), 32'd1);
      ifc.out_ready = 1'b1;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      check("hs_valid", 32'(ifc.out_valid), 32'd0);
      check("hs_busy", 32'(ifc.busy), 32'd0);
      @(posedge clk); #1;
      check("start_ignored", 32'(ifc.busy), 32'd0);
    end
  endtask

  task automatic set_taps(input logic [W-1:0] d, input logic [W-1:0] w);
    for (int i = 0; i < 4; i++) begin
      tap_d[i] = d;
      tap_w[i] = w;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int sd, sw, sb, acc;
    ifc.start = 1'b0; ifc.bias = '0; ifc.in_valid = 1'b0;
    ifc.in_data = '0; ifc.in_weight = '0; ifc.out_ready = 1'b1;
    #12;
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_rdy", 32'(ifc.in_ready), 32'd0);
    check("rst_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_data", ifc.out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_taps(ONE, TWO);
    run_job(ONE, 32'h0004_8000, 1'b0, 1'b0);
    run_job(ONE, 32'h0004_8000, 1'b1, 1'b0);
    run_job(ONE, 32'h0004_8000, 1'b0, 1'b1);

    set_taps(32'h7FFF_FFFF, TWO);
    run_job(32'h0, 32'h7FFF_FFFF, 1'b0, 1'b0);

    set_taps(32'h0, 32'h0);
`ifdef CONV_RELU_EN
    run_job(32'h8000_8000, 32'h0000_0000, 1'b0, 1'b0);
`else
    run_job(32'h8000_8000, 32'h8000_8000, 1'b0, 1'b0);
`endif

    // Reset partway through a job: two taps then async reset.
    set_taps(ONE, TWO);
    ifc.start = 1'b1; ifc.bias = ONE;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    send_tap(0, 1'b0);
    send_tap(1, 1'b0);
    ifc.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_rdy", 32'(ifc.in_ready), 32'd0);
    check("midrst_valid", 32'(ifc.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(ONE, 32'h0004_8000, 1'b0, 1'b0);

    // Random small-integer jobs, exact in Q15 with no saturation.
    for (int j = 0; j < 6; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        sd = $urandom_range(16) - 8;
        sw = $urandom_range(16) - 8;
        tap_d[i] = enc(sd);
        tap_w[i] = enc(sw);
        acc += sd * sw;
      end
      sb = $urandom_range(40) - 20;
      acc += sb;
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      run_job(enc(sb), enc(acc), j[0], 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
